// File: rtl/ref_column_skew_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ref_column_skew_fifo
// Brief    : Reference-column skew buffer for the 8x8 block-matching motion
//            estimator. Accepts one column of PIXELS_IN_BATCH+EDGE_LEN-1
//            pixels per cycle and presents EDGE_LEN row windows. Row k is
//            the PIXELS_IN_BATCH-pixel window starting at pixel k of the
//            column entered k+1 cycles earlier. This produces the systolic
//            skew expected by the absolute-difference array.
// Options  : REF_FIFO_CLR_EN - adds clr_i, a synchronous clear of all stages
// Revision : 1.0 - initial release
// ============================================================================
module ref_column_skew_fifo #(
  parameter int PIXELS_IN_BATCH = 16,
  parameter int EDGE_LEN        = 8,   // port list is fixed at 8 rows
  parameter int BIT_DEPTH       = 8
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
`ifdef REF_FIFO_CLR_EN
  input  logic                                            clr_i,
`endif
  input  logic [(PIXELS_IN_BATCH+EDGE_LEN-1)*BIT_DEPTH-1:0] data_in,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out0,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out1,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out2,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out3,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out4,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out5,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out6,
  output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]            data_out7
);

  localparam int c_COL_PIX = PIXELS_IN_BATCH + EDGE_LEN - 1;
  localparam int c_ROW_W   = PIXELS_IN_BATCH * BIT_DEPTH;

  // Synchronous clear request; tied off when the option is not built.
  logic w_clr;
`ifdef REF_FIFO_CLR_EN
  assign w_clr = clr_i;
`else
  assign w_clr = 1'b0;
`endif

  // Row windows gathered from every stage before fan-out to the ports.
  logic [EDGE_LEN-1:0][c_ROW_W-1:0] w_row;

  // Stage k only ever needs pixels k..c_COL_PIX-1, so each stage drops the
  // lowest pixel of its predecessor. Outputs stay bit-identical to a
  // full-width delay line while the storage shrinks one pixel per stage.
  generate
    for (genvar k = 0; k < EDGE_LEN; k++) begin : g_stage
      localparam int c_W = (c_COL_PIX - k) * BIT_DEPTH;

      logic [c_W-1:0] w_din;
      logic [c_W-1:0] r_stage;

      if (k == 0) begin : g_head
        assign w_din = data_in;
      end else begin : g_tail
        assign w_din = g_stage[k-1].r_stage[c_W+BIT_DEPTH-1:BIT_DEPTH];
      end

      // Unconditional shift; async reset and sync clear both empty the stage.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_stage <= '0;
        end else if (w_clr) begin
          r_stage <= '0;
        end else begin
          r_stage <= w_din;
        end
      end

      // Lowest PIXELS_IN_BATCH stored pixels are exactly window k..k+15.
      assign w_row[k] = r_stage[c_ROW_W-1:0];
    end
  endgenerate

  assign data_out0 = w_row[0];
  assign data_out1 = w_row[1];
  assign data_out2 = w_row[2];
  assign data_out3 = w_row[3];
  assign data_out4 = w_row[4];
  assign data_out5 = w_row[5];
  assign data_out6 = w_row[6];
  assign data_out7 = w_row[7];

endmodule
`default_nettype wire

// File: tb/tb_ref_column_skew_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ref_column_skew_fifo
// Brief    : Self-checking bench for ref_column_skew_fifo. A history of
//            accepted columns models the delay line; row k is rebuilt from
//            pixel arithmetic on the column k edges back.
// Options  : REF_FIFO_CLR_EN - exercises the synchronous clear when defined
// Revision : 1.0 - initial release
// ============================================================================
module tb_ref_column_skew_fifo;

  localparam int PIB   = 16;
  localparam int EDGE  = 8;
  localparam int BD    = 8;
  localparam int NPIX  = PIB + EDGE - 1;
  localparam int COL_W = NPIX * BD;
  localparam int ROW_W = PIB * BD;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             clr_i = 1'b0;
  logic [COL_W-1:0] data_in = '0;
  logic [ROW_W-1:0] dout [EDGE];

  int errors = 0;
  int checks = 0;

  // Columns accepted since the last clear, newest first.
  logic [COL_W-1:0] hist[$];

  always #5 clk_i = ~clk_i;

  ref_column_skew_fifo #(
    .PIXELS_IN_BATCH(PIB),
    .EDGE_LEN       (EDGE),
    .BIT_DEPTH      (BD)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
`ifdef REF_FIFO_CLR_EN
    .clr_i    (clr_i),
`endif
    .data_in  (data_in),
    .data_out0(dout[0]),
    .data_out1(dout[1]),
    .data_out2(dout[2]),
    .data_out3(dout[3]),
    .data_out4(dout[4]),
    .data_out5(dout[5]),
    .data_out6(dout[6]),
    .data_out7(dout[7])
  );

  function automatic logic [ROW_W-1:0] window(input logic [COL_W-1:0] col, input int k);
    logic [ROW_W-1:0] w;
    for (int j = 0; j < PIB; j++) w[j*BD +: BD] = col[(k+j)*BD +: BD];
    return w;
  endfunction

  function automatic logic [ROW_W-1:0] expect_row(input int k);
    if (hist.size() > k) return window(hist[k], k);
    return '0;
  endfunction

  task automatic check_vec(input string tag, input int k,
                           input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s row=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic check_byte(input string tag, input int k,
                            input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s row=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < EDGE; k++) check_vec(tag, k, dout[k], expect_row(k));
  endtask

  // One clock: present col, let the edge take it, then compare all rows.
  task automatic tick(input string tag, input logic [COL_W-1:0] col);
    data_in = col;
    @(posedge clk_i);
    hist.push_front(col);
    if (hist.size() > EDGE) void'(hist.pop_back());
    #1;
    check_all(tag);
  endtask

  function automatic logic [COL_W-1:0] rand_col();
    logic [COL_W-1:0] c;
    for (int p = 0; p < NPIX; p++) c[p*BD +: BD] = 8'($urandom);
    return c;
  endfunction

  logic [COL_W-1:0] single_col;
  logic [COL_W-1:0] sweep_col;
  int               nonzero_cycles [EDGE];

  initial begin
    single_col = {8'h0c, 8'ha7, 8'hec, 8'h79, 8'he7, 8'h2d, 8'h17, 8'h10,
                  8'h41, 8'h65, 8'hee, 8'h01, 8'heb, 8'h26, 8'h06, 8'h69,
                  8'hb1, 8'hb7, 8'h54, 8'hbb, 8'hee, 8'hdd, 8'h13};
    for (int p = 0; p < NPIX; p++) sweep_col[p*BD +: BD] = 8'(p);

    // Reset held across an edge with arbitrary input: everything reads 0.
    #1;
    rst_i   = 1'b1;
    data_in = rand_col();
    #6;
    hist.delete();
    check_all("reset_hold");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) tick("post_reset_zero", '0);

    // Single column followed by zeros.
    for (int k = 0; k < EDGE; k++) nonzero_cycles[k] = 0;
    tick("single", single_col);
    check_byte("single_o0_p0", 0, dout[0][7:0], 8'h13);
    check_byte("single_o0_p1", 0, dout[0][15:8], 8'hdd);
    check_byte("single_o0_p15", 0, dout[0][127:120], 8'h10);
    for (int k = 0; k < EDGE; k++) if (dout[k] != '0) nonzero_cycles[k]++;
    for (int i = 1; i < 10; i++) begin
      if (i < 7) check_vec("single_o7_empty", 7, dout[7], '0);
      tick("single_flush", '0);
      if (i == 7) begin
        check_byte("single_o7_p0", 7, dout[7][7:0], 8'h69);
        check_byte("single_o7_p15", 7, dout[7][127:120], 8'h0c);
      end
      for (int k = 0; k < EDGE; k++) if (dout[k] != '0) nonzero_cycles[k]++;
    end
    for (int k = 0; k < EDGE; k++) begin
      checks++;
      assert (nonzero_cycles[k] == 1) else begin
        errors++;
        $error("FAIL single_once row=%0d got=%0d exp=1", k, nonzero_cycles[k]);
      end
    end

    // Streaming random columns at full rate, then drain.
    for (int i = 0; i < 10; i++) tick("stream", rand_col());
    for (int i = 0; i < EDGE; i++) tick("stream_drain", '0);

    // Asynchronous reset between edges mid-stream, then refill.
    for (int i = 0; i < 5; i++) tick("pre_reset", rand_col());
    #2;
    rst_i = 1'b1;
    #1;
    hist.delete();
    check_all("async_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    tick("refill", single_col);
    for (int i = 0; i < EDGE; i++) tick("refill_flush", '0);

    // Pixel-index sweep: row k window pixel j must be k+j.
    tick("sweep", sweep_col);
    for (int k = 0; k < EDGE; k++) begin
      for (int j = 0; j < PIB; j++)
        check_byte("sweep_pix", k, dout[k][j*BD +: BD], 8'(k + j));
      if (k < EDGE - 1) tick("sweep_flush", '0);
    end

`ifdef REF_FIFO_CLR_EN
    // Synchronous clear with a full line discards everything, including
    // the column presented on the clearing edge.
    for (int i = 0; i < EDGE; i++) tick("pre_clr", rand_col());
    clr_i   = 1'b1;
    data_in = rand_col();
    @(posedge clk_i);
    hist.delete();
    #1;
    clr_i = 1'b0;
    check_all("clr");
    tick("post_clr", single_col);
    check_byte("post_clr_o0_p0", 0, dout[0][7:0], 8'h13);
    for (int i = 0; i < 3; i++) tick("post_clr_flush", rand_col());
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ref_column_skew_fifo.md
Name: ref_column_skew_fifo

Overview:
- Reference-column skew buffer for the 8x8 block-matching motion-estimation datapath.
- Each cycle it accepts one reference column of PIXELS_IN_BATCH+EDGE_LEN-1 pixels (23 for the default parameters).
- It drives EDGE_LEN (8) row outputs. Row k is a PIXELS_IN_BATCH-pixel (16-pixel) window starting at pixel k, delayed k+1 cycles.
- The outputs concatenate into the 1024-bit reference_input_column bus of the absolute-difference array, giving the systolic skew that array expects.

Parameters:
- PIXELS_IN_BATCH, 16: candidate positions per batch, i.e. pixels per output row.
- EDGE_LEN, 8: block edge length. The port list is fixed at 8 outputs, so this must be 8.
- BIT_DEPTH, 8: bits per pixel.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_in  in  (PIXELS_IN_BATCH+EDGE_LEN-1)*BIT_DEPTH = 184  reference column.
  - Pixel p occupies bits [(p+1)*BIT_DEPTH-1 : p*BIT_DEPTH]; pixel 0 is the LSB.
- data_out0 .. data_out7  out  PIXELS_IN_BATCH*BIT_DEPTH = 128 each.
  - data_outk: window of pixels k..k+PIXELS_IN_BATCH-1 taken from the column entered k+1 cycles earlier.
  - Window pixel j (pixel k+j of that column) sits at bits [(j+1)*8-1 : j*8].

Behaviour:
- Delay line: EDGE_LEN registers s0..s7, each a full 184-bit column.
- Every rising edge with rst_i low:
  - s0 <= data_in;
  - sk <= s(k-1) for k = 1..7.
  - No enable: the line shifts unconditionally every cycle.
- Outputs:
  - data_outk = sk[(k+PIXELS_IN_BATCH)*BIT_DEPTH-1 : k*BIT_DEPTH].
  - Purely combinational slice of a register; no logic between register and port.
  - Only the used pixels need be stored: stage k keeps pixels k..22. Any narrower storage must give bit-identical outputs.
- Latency:
  - A column sampled at edge n appears on data_out0 after edge n.
  - It appears on data_outk after edge n+k.
  - Throughput is 1 column per cycle.
- Reset:
  - rst_i high clears every stage immediately, independent of the clock, so all data_out* read 0.
  - Reset held: outputs stay 0 and data_in is ignored.
  - Reset asserted mid-stream: all in-flight columns are discarded.
- First edge after reset release samples data_in. Stages not yet filled keep driving 0, so the data_outk window stays 0 for k cycles after data_out0 is first valid.
- data_in X/undriven before the first valid column simply propagates; no checking is done.
- No overflow or underflow conditions exist: fixed depth, always full.

Optional Feature:
- Macro: REF_FIFO_CLR_EN.
- Defined:
  - Adds input port clr_i (1 bit), a synchronous clear.
  - On a rising edge with clr_i high and rst_i low, all stages load 0. This takes priority over shifting, and data_in on that edge is discarded.
  - Outputs read 0 from that edge.
  - rst_i still has priority over clr_i.
- Not defined: no clr_i port; behaviour exactly as above.

Test Plan:
- Reset: rst_i=1 for 6 ns with arbitrary data_in → all eight data_out* = 0. Drop rst_i; with data_in=0, outputs stay 0.
- Single column, data_in = {0c,a7,ec,79,e7,2d,17,10,41,65,ee,01,eb,26,06,69,b1,b7,54,bb,ee,dd,13} (MSB byte first), then data_in=0:
  - After the first edge: data_out0[7:0]=0x13, data_out0[15:8]=0xdd, data_out0[127:120]=0x10.
  - data_out7 reads 0 until 7 edges later, then [7:0]=0x69 and [127:120]=0x0c.
  - Each output is non-zero for exactly one cycle.
- Streaming: 10 consecutive distinct columns at 1/clock → data_outk in cycle t equals the k-offset window of the column entered at cycle t-k. Check all 8 outputs each cycle against a reference model.
- Mid-stream reset: pulse rst_i asynchronously between edges during streaming → all outputs go 0 before the next edge. After release, the pipeline refills from 0 as in the single-column case.
- Pixel-index sweep: data_in pixel p = p (0x00..0x16) → data_outk window pixel j = k+j, for all k = 0..7 and j = 0..15.
- REF_FIFO_CLR_EN defined: assert clr_i for 1 cycle while the line is full → all outputs 0 after that edge. The next column then reappears on data_out0 one edge later.
